// File: rtl/decode_lut_pkg.sv
// Control-word layout shared by the decode table, its bus interface and benches.
// Field order fixes the packing of the cfg_word write port.
package decode_pkg;
   localparam int REG_W    = 4;
   localparam int ALU_OP_W = 4;
   localparam int PC_W     = 16;
   localparam int DATA_W   = 8;

   typedef struct packed {
      logic                mem_w;
      logic                rf_w;
      logic [ALU_OP_W-1:0] alu_op;
      logic [REG_W-1:0]    rs_addr;
      logic [REG_W-1:0]    rt_addr;
      logic [REG_W-1:0]    rd_addr;
      logic [PC_W-1:0]     imm_pc;
      logic [DATA_W-1:0]   alu_in;
      logic                alu_sel;
   } ctrl_t;

   localparam int    CTRL_W   = $bits(ctrl_t);
   localparam ctrl_t CTRL_NOP = '0;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
endpackage

// File: rtl/decode_lut_if.sv
// Decode stage bus: op input handshake, control-word output handshake, table config port.
// slave is the decode stage; master is the fetch/consumer/config side.
interface decode_lut_if
   import decode_pkg::*;
#(
   parameter int OP_W  = 9,
   parameter int IDX_W = 6
) ();
   logic              in_valid;
   logic              in_ready;
   logic [OP_W-1:0]   op_i;
   logic              out_valid;
   logic              out_ready;
   logic              mem_w;
   logic              rf_w;
   logic              alu_sel;
   logic [ALU_OP_W-1:0] alu_op;
   logic [REG_W-1:0]  rs_addr;
   logic [REG_W-1:0]  rt_addr;
   logic [REG_W-1:0]  rd_addr;
   logic [PC_W-1:0]   imm_pc;
   logic [DATA_W-1:0] alu_in;
   logic              illegal_o;
   logic              cfg_we;
   logic [IDX_W-1:0]  cfg_idx;
   ctrl_t             cfg_word;
   logic [15:0]       miss_cnt;

   modport slave (
      input  in_valid, op_i, out_ready, cfg_we, cfg_idx, cfg_word,
      output in_ready, out_valid, mem_w, rf_w, alu_sel, alu_op, rs_addr, rt_addr,
             rd_addr, imm_pc, alu_in, illegal_o, miss_cnt
   );

   modport master (
      output in_valid, op_i, out_ready, cfg_we, cfg_idx, cfg_word,
      input  in_ready, out_valid, mem_w, rf_w, alu_sel, alu_op, rs_addr, rt_addr,
             rd_addr, imm_pc, alu_in, illegal_o, miss_cnt
   );
endinterface

// File: rtl/decode_lut_lut_mem.sv
// Decode table storage: one synchronous write port, one combinational read port.
// Contents are unreset; validity is tracked by the owner.
module lut_mem
   import decode_pkg::*;
#(
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] widx,
   input  ctrl_t            wdat,
   input  logic [IDX_W-1:0] ridx,
   output ctrl_t            rdat
);
   localparam int DEPTH = 1 << IDX_W;

   ctrl_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[widx] <= wdat;
      end
   end

   assign rdat = mem[ridx];
endmodule

// File: rtl/decode_lut.sv
// Programmable instruction decode: op -> control word, one registered stage.
// Latency 1; in_ready = !out_valid || out_ready, outputs hold while stalled.
module decode_lut
   import decode_pkg::*;
#(
   parameter int OP_W  = 9,
   parameter int IDX_W = 6
) (
   input  logic         clk,
   input  logic         reset_n,
   decode_lut_if.slave  bus
);
   localparam int DEPTH = 1 << IDX_W;

   logic [IDX_W-1:0] idx;
   logic [DEPTH-1:0] entry_vld;
   ctrl_t            rd_word;
   ctrl_t            lk_word;
   ctrl_t            ctrl_q;
   logic             fire;
   logic             bypass;
   logic             hit;
   logic             illegal_q;
   logic             out_valid_q;
   logic [15:0]      miss_q;
   logic             unused_op_hi;

   // Upper opcode bits alias onto the same table entry.
   assign idx          = bus.op_i[IDX_W-1:0];
   assign unused_op_hi = ^bus.op_i[OP_W-1:IDX_W];

   lut_mem #(.IDX_W(IDX_W)) u_mem (
      .clk  (clk),
      .we   (bus.cfg_we),
      .widx (bus.cfg_idx),
      .wdat (bus.cfg_word),
      .ridx (idx),
      .rdat (rd_word)
   );

   assign bus.in_ready = !out_valid_q || bus.out_ready;
   assign fire         = bus.in_valid && bus.in_ready;
   assign bypass       = bus.cfg_we && (bus.cfg_idx == idx);
   assign hit          = bypass || entry_vld[idx];

   always_comb begin
      lk_word = CTRL_NOP;
      if (bypass) begin
         lk_word = bus.cfg_word;
      end else if (entry_vld[idx]) begin
         lk_word = rd_word;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         entry_vld <= '0;
      end else if (bus.cfg_we) begin
         entry_vld[bus.cfg_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         ctrl_q      <= CTRL_NOP;
         illegal_q   <= 1'b0;
      end else if (fire) begin
         out_valid_q <= 1'b1;
         ctrl_q      <= lk_word;
         illegal_q   <= !hit;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         miss_q <= '0;
      end else if (fire && !hit) begin
         miss_q <= sat_inc(miss_q);
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.mem_w     = ctrl_q.mem_w;
   assign bus.rf_w      = ctrl_q.rf_w;
   assign bus.alu_op    = ctrl_q.alu_op;
   assign bus.rs_addr   = ctrl_q.rs_addr;
   assign bus.rt_addr   = ctrl_q.rt_addr;
   assign bus.rd_addr   = ctrl_q.rd_addr;
   assign bus.imm_pc    = ctrl_q.imm_pc;
   assign bus.alu_in    = ctrl_q.alu_in;
   assign bus.alu_sel   = ctrl_q.alu_sel;
   assign bus.illegal_o = illegal_q;
   assign bus.miss_cnt  = miss_q;
endmodule

// File: tb/tb_decode_lut.sv
// Bench for decode_lut: directed vector table, stall/reset sequences, random traffic
// against a table-plus-queue reference model.
module tb_decode_lut;
   import decode_pkg::*;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   decode_lut_if bus ();

   decode_lut #(.OP_W(9), .IDX_W(6)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      ctrl_t c;
      logic  ill;
   } res_t;

   typedef struct {
      logic        vld;
      logic [8:0]  op;
      logic        we;
      logic [5:0]  widx;
      ctrl_t       word;
      logic        e_ov;
      ctrl_t       e_c;
      logic        e_ill;
      logic [15:0] e_miss;
   } vec_t;

   res_t        exp_q[$];
   ctrl_t       m_tbl [64];
   logic        m_vld [64];
   int unsigned m_miss;
   int          errors = 0;
   int          checks = 0;

   ctrl_t w0, w5, w8, w10, w11, w12;
   vec_t  vt [9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   function automatic ctrl_t dut_ctrl();
      return {bus.mem_w, bus.rf_w, bus.alu_op, bus.rs_addr, bus.rt_addr, bus.rd_addr,
              bus.imm_pc, bus.alu_in, bus.alu_sel};
   endfunction

   task automatic model_reset();
      exp_q.delete();
      for (int i = 0; i < 64; i++) m_vld[i] = 1'b0;
      m_miss = 0;
   endtask

   task automatic check_state();
      chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         chk("ctrl", 64'(dut_ctrl()), 64'(exp_q[0].c));
         chk("illegal", 64'(bus.illegal_o), 64'(exp_q[0].ill));
      end
      chk("miss_cnt", 64'(bus.miss_cnt), 64'(m_miss));
   endtask

   // Called at a negedge: drive, predict the coming edge, then check after it.
   task automatic tick(input logic v, input logic [8:0] op, input logic rdy,
                       input logic we, input logic [5:0] widx, input ctrl_t wword);
      logic mrdy;
      res_t r;
      int   i;
      bus.in_valid  = v;
      bus.op_i      = op;
      bus.out_ready = rdy;
      bus.cfg_we    = we;
      bus.cfg_idx   = widx;
      bus.cfg_word  = wword;
      #1;
      mrdy = (exp_q.size() == 0) || rdy;
      chk("in_ready", 64'(bus.in_ready), 64'(mrdy));
      if (exp_q.size() != 0 && rdy) exp_q.delete(0);
      if (v && mrdy) begin
         i = int'(op[5:0]);
         if (we && widx == op[5:0]) begin
            r.c = wword;  r.ill = 1'b0;
         end else if (m_vld[i]) begin
            r.c = m_tbl[i]; r.ill = 1'b0;
         end else begin
            r.c = CTRL_NOP; r.ill = 1'b1;
            if (m_miss < 65535) m_miss++;
         end
         exp_q.push_back(r);
      end
      if (we) begin
         m_tbl[widx] = wword;
         m_vld[widx] = 1'b1;
      end
      @(negedge clk);
      check_state();
   endtask

   initial begin
      logic [63:0] rnd;
      logic [8:0]  rop;
      logic [5:0]  ridx;
      ctrl_t       rword;

      w0  = '{mem_w:1'b0, rf_w:1'b1, alu_op:4'd1, rs_addr:4'd0, rt_addr:4'd1, rd_addr:4'd2,
              imm_pc:16'h000F, alu_in:8'd29, alu_sel:1'b0};
      w5  = '{mem_w:1'b1, rf_w:1'b0, alu_op:4'd9, rs_addr:4'd3, rt_addr:4'd4, rd_addr:4'd5,
              imm_pc:16'hBEEF, alu_in:8'hA5, alu_sel:1'b1};
      w8  = '{mem_w:1'b1, rf_w:1'b1, alu_op:4'd15, rs_addr:4'd15, rt_addr:4'd0, rd_addr:4'd8,
              imm_pc:16'h8001, alu_in:8'h7E, alu_sel:1'b0};
      w10 = w0;  w10.rd_addr = 4'd10; w10.imm_pc = 16'h1010;
      w11 = w5;  w11.rd_addr = 4'd11; w11.imm_pc = 16'h1111;
      w12 = w8;  w12.rd_addr = 4'd12; w12.imm_pc = 16'h1212;

      vt[0] = '{1'b1, 9'h000, 1'b0, 6'd0, CTRL_NOP, 1'b1, CTRL_NOP, 1'b1, 16'd1};
      vt[1] = '{1'b0, 9'h000, 1'b1, 6'd0, w0,       1'b0, CTRL_NOP, 1'b0, 16'd1};
      vt[2] = '{1'b1, 9'h040, 1'b0, 6'd0, CTRL_NOP, 1'b1, w0,       1'b0, 16'd1};
      vt[3] = '{1'b1, 9'h005, 1'b1, 6'd5, w5,       1'b1, w5,       1'b0, 16'd1};
      vt[4] = '{1'b1, 9'h1C5, 1'b0, 6'd0, CTRL_NOP, 1'b1, w5,       1'b0, 16'd1};
      vt[5] = '{1'b1, 9'h007, 1'b0, 6'd0, CTRL_NOP, 1'b1, CTRL_NOP, 1'b1, 16'd2};
      vt[6] = '{1'b1, 9'h007, 1'b1, 6'd8, w8,       1'b1, CTRL_NOP, 1'b1, 16'd3};
      vt[7] = '{1'b1, 9'h008, 1'b0, 6'd0, CTRL_NOP, 1'b1, w8,       1'b0, 16'd3};
      vt[8] = '{1'b0, 9'h000, 1'b0, 6'd0, CTRL_NOP, 1'b0, CTRL_NOP, 1'b0, 16'd3};

      reset_n       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.op_i      = '0;
      bus.out_ready = 1'b0;
      bus.cfg_we    = 1'b0;
      bus.cfg_idx   = '0;
      bus.cfg_word  = CTRL_NOP;
      repeat (2) @(negedge clk);
      chk("rst out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst ctrl", 64'(dut_ctrl()), 64'd0);
      chk("rst illegal", 64'(bus.illegal_o), 64'd0);
      chk("rst miss_cnt", 64'(bus.miss_cnt), 64'd0);
      chk("rst in_ready", 64'(bus.in_ready), 64'd1);
      model_reset();
      reset_n = 1'b1;

      for (int k = 0; k < 9; k++) begin
         tick(vt[k].vld, vt[k].op, 1'b1, vt[k].we, vt[k].widx, vt[k].word);
         chk($sformatf("vec%0d out_valid", k), 64'(bus.out_valid), 64'(vt[k].e_ov));
         if (vt[k].e_ov) begin
            chk($sformatf("vec%0d ctrl", k), 64'(dut_ctrl()), 64'(vt[k].e_c));
            chk($sformatf("vec%0d illegal", k), 64'(bus.illegal_o), 64'(vt[k].e_ill));
         end
         chk($sformatf("vec%0d miss_cnt", k), 64'(bus.miss_cnt), 64'(vt[k].e_miss));
      end

      // Three ops back-to-back with the consumer stalled for two cycles.
      tick(1'b0, 9'd0, 1'b1, 1'b1, 6'd10, w10);
      tick(1'b0, 9'd0, 1'b1, 1'b1, 6'd11, w11);
      tick(1'b0, 9'd0, 1'b1, 1'b1, 6'd12, w12);
      tick(1'b1, 9'd10, 1'b0, 1'b0, 6'd0, CTRL_NOP);
      chk("stall first", 64'(dut_ctrl()), 64'(w10));
      tick(1'b1, 9'd11, 1'b0, 1'b0, 6'd0, CTRL_NOP);
      chk("stall hold1", 64'(dut_ctrl()), 64'(w10));
      chk("stall in_ready", 64'(bus.in_ready), 64'd0);
      tick(1'b1, 9'd11, 1'b0, 1'b0, 6'd0, CTRL_NOP);
      chk("stall hold2", 64'(dut_ctrl()), 64'(w10));
      chk("stall valid", 64'(bus.out_valid), 64'd1);
      tick(1'b1, 9'd11, 1'b1, 1'b0, 6'd0, CTRL_NOP);
      chk("stall second", 64'(dut_ctrl()), 64'(w11));
      tick(1'b1, 9'd12, 1'b1, 1'b0, 6'd0, CTRL_NOP);
      chk("stall third", 64'(dut_ctrl()), 64'(w12));
      tick(1'b0, 9'd0, 1'b1, 1'b0, 6'd0, CTRL_NOP);
      chk("stall drain", 64'(bus.out_valid), 64'd0);

      for (int n = 0; n < 600; n++) begin
         rop   = 9'($urandom);
         ridx  = ($urandom_range(0, 1) != 0) ? rop[5:0] : 6'($urandom);
         rnd   = {$urandom, $urandom};
         rword = rnd[CTRL_W-1:0];
         tick($urandom_range(0, 3) != 0, rop, $urandom_range(0, 3) != 0,
              $urandom_range(0, 3) == 0, ridx, rword);
      end
      tick(1'b0, 9'd0, 1'b1, 1'b0, 6'd0, CTRL_NOP);

      // Saturation: empty table after reset, then a long run of misses.
      reset_n = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      reset_n       = 1'b1;
      bus.in_valid  = 1'b1;
      bus.op_i      = 9'h03F;
      bus.out_ready = 1'b1;
      bus.cfg_we    = 1'b0;
      repeat (65534) @(negedge clk);
      exp_q.push_back('{CTRL_NOP, 1'b1});
      m_miss = 65534;
      check_state();
      for (int n = 0; n < 3; n++) tick(1'b1, 9'h03F, 1'b1, 1'b0, 6'd0, CTRL_NOP);
      chk("miss saturated", 64'(bus.miss_cnt), 64'hFFFF);
      tick(1'b0, 9'd0, 1'b1, 1'b0, 6'd0, CTRL_NOP);

      // Asynchronous reset while an output is stalled.
      tick(1'b0, 9'd0, 1'b1, 1'b1, 6'd3, w10);
      tick(1'b1, 9'd3, 1'b0, 1'b0, 6'd0, CTRL_NOP);
      tick(1'b1, 9'd4, 1'b0, 1'b0, 6'd0, CTRL_NOP);
      chk("pre-reset valid", 64'(bus.out_valid), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("arst out_valid", 64'(bus.out_valid), 64'd0);
      chk("arst ctrl", 64'(dut_ctrl()), 64'd0);
      chk("arst illegal", 64'(bus.illegal_o), 64'd0);
      chk("arst miss_cnt", 64'(bus.miss_cnt), 64'd0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      tick(1'b1, 9'd3, 1'b1, 1'b0, 6'd0, CTRL_NOP);
      chk("post-reset illegal", 64'(bus.illegal_o), 64'd1);
      chk("post-reset ctrl", 64'(dut_ctrl()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
